// File: rtl/audio_serial_tx_pkg.sv
// Shared types for the audio transmit serializer: sample and left/right pair.
package audio_tx_pkg;

  localparam int SAMPLE_W = 24;
  localparam int SLOT_W   = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } sample_pair_t;

endpackage

// File: rtl/audio_serial_tx_if.sv
// Sample-pair write port (valid/ready style) between a producer and audio_serial_tx.
interface audio_tx_if;
  import audio_tx_pkg::*;

  logic    write;
  sample_t writedata_left;
  sample_t writedata_right;
  logic    write_ready;

  modport master (output write, writedata_left, writedata_right, input write_ready);
  modport slave  (input write, writedata_left, writedata_right, output write_ready);

endinterface

// File: rtl/audio_serial_tx_fifo.sv
// Small synchronous FIFO of left/right sample pairs with registered pointers.
module tx_pair_fifo
  import audio_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  sample_pair_t din,
  output sample_pair_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  sample_pair_t   mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_serial_tx.sv
// I2S transmit serializer: FIFO-buffered sample pairs shifted out MSB-first on bclk/lrclk/dacdat.
// Optional AUDIO_TX_HOLD_LAST_EN: on underflow retransmit the last pair instead of zeros.
module audio_serial_tx
  import audio_tx_pkg::*;
#(
  parameter int SAMPLE_W   = audio_tx_pkg::SAMPLE_W,
  parameter int SLOT_W     = audio_tx_pkg::SLOT_W,
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  audio_tx_if.slave  wr,
  output logic       bclk,
  output logic       lrclk,
  output logic       dacdat,
  output logic       underflow
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2*SLOT_W);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_nxt;
  logic [BIT_W-1:0]    slot_pos;
  logic                div_tc;
  logic                fall;
  logic                right_nxt;
  logic                data_bit;
  logic                fetch;
  logic [SAMPLE_W-1:0] sh_l;
  logic [SAMPLE_W-1:0] sh_r;

  sample_pair_t        fifo_din;
  sample_pair_t        fifo_dout;
  sample_pair_t        fill;
  sample_pair_t        src;
  logic                fifo_full;
  logic                fifo_empty;

  assign fifo_din       = '{left: wr.writedata_left, right: wr.writedata_right};
  assign wr.write_ready = !fifo_full;

  tx_pair_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr.write),
    .pop     (fetch),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign div_tc    = (div_cnt == DIV_W'(BCLK_DIV-1));
  assign fall      = div_tc && bclk;
  assign bit_nxt   = (bit_cnt == BIT_W'(2*SLOT_W-1)) ? '0 : bit_cnt + BIT_W'(1);
  assign right_nxt = (bit_nxt >= BIT_W'(SLOT_W));
  assign slot_pos  = right_nxt ? bit_nxt - BIT_W'(SLOT_W) : bit_nxt;
  // slot_pos 0 is the I2S one-bit delay; sample bits occupy positions 1..SAMPLE_W.
  assign data_bit  = (slot_pos != '0) && (slot_pos <= BIT_W'(SAMPLE_W));
  assign fetch     = fall && (bit_nxt == '0);

`ifdef AUDIO_TX_HOLD_LAST_EN
  sample_pair_t held;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held <= '0;
    end else if (fetch && !fifo_empty) begin
      held <= fifo_dout;
    end
  end

  assign fill = held;
`else
  assign fill = '0;
`endif

  assign src = fifo_empty ? fill : fifo_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      bclk      <= 1'b0;
      bit_cnt   <= BIT_W'(2*SLOT_W-1);
      lrclk     <= 1'b0;
      dacdat    <= 1'b0;
      underflow <= 1'b0;
      sh_l      <= '0;
      sh_r      <= '0;
    end else begin
      underflow <= fetch && fifo_empty;
      div_cnt   <= div_tc ? '0 : div_cnt + DIV_W'(1);
      if (div_tc) bclk <= !bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= right_nxt;
        if (fetch) begin
          dacdat <= 1'b0;
          sh_l   <= src.left;
          sh_r   <= src.right;
        end else if (data_bit && right_nxt) begin
          dacdat <= sh_r[SAMPLE_W-1];
          sh_r   <= sh_r << 1;
        end else if (data_bit) begin
          dacdat <= sh_l[SAMPLE_W-1];
          sh_l   <= sh_l << 1;
        end else begin
          dacdat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_serial_tx.sv
// Scoreboard bench for audio_serial_tx: a pair model feeds per-frame expectations to a serial monitor.
module tb_audio_serial_tx;
  import audio_tx_pkg::*;

  localparam int BCLK_DIV = 8;
  localparam int SLOT_W   = 32;
  localparam int SW       = 24;
  localparam int DEPTH    = 4;
  localparam int FIRST    = 2*BCLK_DIV;
  localparam int FRAME    = 2*SLOT_W*2*BCLK_DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic bclk, lrclk, dacdat, underflow;

  audio_tx_if wr();

  audio_serial_tx #(
    .SAMPLE_W(SW), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .dacdat    (dacdat),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_miss = 0;
  int           n_frames = 0;
  int           cyc = 0;
  sample_pair_t mq[$];
  sample_pair_t fq[$];
  sample_pair_t hold = '0;
  bit           exp_uf = 1'b0;

  logic [SW-1:0] tbl_l [6] = '{24'h000001, 24'h5A5A5A, 24'h7FFFFF, 24'h0F0F0F, 24'h999999, 24'h424242};
  logic [SW-1:0] tbl_r [6] = '{24'hFFFFFE, 24'hA5A5A5, 24'h800000, 24'hF0F0F0, 24'h666666, 24'h242424};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    wr.write           = 1'b1;
    wr.writedata_left  = l;
    wr.writedata_right = r;
    @(negedge clk);
    wr.write = 1'b0;
  endtask

  // Reference model: FIFO occupancy and frame fetch, pushing one expectation per frame.
  initial begin
    sample_pair_t p;
    bit is_fetch, full_pre, do_push;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        cyc = 0;
        mq.delete();
        fq.delete();
        hold = '0;
        exp_uf = 1'b0;
      end else begin
        cyc++;
        is_fetch = (cyc >= FIRST) && (((cyc - FIRST) % FRAME) == 0);
        full_pre = (mq.size() >= DEPTH);
        do_push  = wr.write && !full_pre;
        exp_uf   = 1'b0;
        if (is_fetch) begin
          if (mq.size() > 0) begin
            p = mq.pop_front();
            hold = p;
            fq.push_back(p);
          end else begin
            exp_uf = 1'b1;
`ifdef AUDIO_TX_HOLD_LAST_EN
            fq.push_back(hold);
`else
            fq.push_back('0);
`endif
          end
        end
        if (do_push) mq.push_back('{left: wr.writedata_left, right: wr.writedata_right});
      end
    end
  end

  // Monitor: per-clk ready/underflow, and dacdat/lrclk captured on each bclk rising edge.
  initial begin
    int           pos = -1;
    bit           prev = 1'b0;
    logic         cap_d  [2*SLOT_W];
    logic         cap_lr [2*SLOT_W];
    sample_pair_t e;
    logic [SW-1:0] l_act, r_act, l_exp, r_exp;
    logic         pad, lr_ok;
    int           j;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pos  = -1;
        prev = 1'b0;
      end else begin
        chk("write_ready", 32'(wr.write_ready), 32'(mq.size() < DEPTH));
        if (exp_uf || underflow) chk("underflow", 32'(underflow), 32'(exp_uf));
        if (bclk && !prev) begin
          if (pos < 0) begin
            pos = 0;
          end else begin
            cap_d[pos]  = dacdat;
            cap_lr[pos] = lrclk;
            pos++;
            if (pos == 2*SLOT_W) begin
              pos = 0;
              if (fq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL frame_expect: frame captured with no expectation queued (cyc %0d)", cyc);
              end else begin
                e = fq.pop_front();
                l_exp = e.left;
                r_exp = e.right;
                l_act = '0;
                r_act = '0;
                pad   = 1'b0;
                lr_ok = 1'b1;
                for (int i = 0; i < 2*SLOT_W; i++) begin
                  j = i % SLOT_W;
                  if (j >= 1 && j <= SW) begin
                    if (i < SLOT_W) l_act = {l_act[SW-2:0], cap_d[i]};
                    else            r_act = {r_act[SW-2:0], cap_d[i]};
                  end else begin
                    pad = pad | cap_d[i];
                  end
                  if (cap_lr[i] !== (i >= SLOT_W)) lr_ok = 1'b0;
                end
                chk("frame_left",  32'(l_act), 32'(l_exp));
                chk("frame_right", 32'(r_act), 32'(r_exp));
                chk("frame_pad",   32'(pad),   32'd0);
                chk("frame_lrclk", 32'(lr_ok), 32'd1);
                n_frames++;
              end
            end
          end
        end
        prev = bclk;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    wr.write           = 1'b0;
    wr.writedata_left  = '0;
    wr.writedata_right = '0;
    reset_n            = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bclk",      32'(bclk),           32'd0);
    chk("rst_lrclk",     32'(lrclk),          32'd0);
    chk("rst_dacdat",    32'(dacdat),         32'd0);
    chk("rst_underflow", 32'(underflow),      32'd0);
    chk("rst_ready",     32'(wr.write_ready), 32'd1);
    reset_n = 1'b1;

    // Idle: first bclk rise at clk 8, underflow at 16 and 1040 via the model
    wait_cyc(7);
    chk("bclk_before_8", 32'(bclk), 32'd0);
    wait_cyc(8);
    chk("bclk_rise_8",   32'(bclk), 32'd1);
    wait_cyc(2100);

    // Single pair written before the first fetch
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(1);
    push_pair(24'h800001, 24'h7FFFFF);
    wait_cyc(31);
    chk("dacdat_delay_bit", 32'(dacdat), 32'd0);
    wait_cyc(32);
    chk("dacdat_msb_32",    32'(dacdat), 32'd1);
    chk("lrclk_left_32",    32'(lrclk),  32'd0);
    wait_cyc(527);
    chk("lrclk_left_end",   32'(lrclk),  32'd0);
    wait_cyc(528);
    chk("lrclk_right_start", 32'(lrclk), 32'd1);

    // Five consecutive writes into a four-deep FIFO
    wait_cyc(1050);
    for (int i = 0; i < 5; i++) begin
      wr.write           = 1'b1;
      wr.writedata_left  = tbl_l[i];
      wr.writedata_right = tbl_r[i];
      @(negedge clk);
      if (i == 3) chk("ready_after_4th", 32'(wr.write_ready), 32'd0);
    end
    wr.write = 1'b0;
    chk("ready_after_5th", 32'(wr.write_ready), 32'd0);

    // Write held across the fetch edge while full: pop happens, push dropped
    wait_cyc(2063);
    wr.write           = 1'b1;
    wr.writedata_left  = tbl_l[5];
    wr.writedata_right = tbl_r[5];
    chk("ready_full_pre_fetch", 32'(wr.write_ready), 32'd0);
    @(negedge clk);
    wr.write = 1'b0;
    chk("ready_after_pop", 32'(wr.write_ready), 32'd1);

    // Hold-last: one pair then starvation
    wait_cyc(6170);
    push_pair(24'h123456, 24'hABCDEF);

    // Fill FIFO, then reset at left bit 10 of the next frame
    wait_cyc(8220);
    push_pair(24'hFFFFFF, 24'h000000);
    push_pair(24'h111111, 24'h222222);
    push_pair(24'h333333, 24'h444444);
    push_pair(24'h555555, 24'h666666);
    wait_cyc(9402);
    chk("pre_rst_bclk",   32'(bclk),   32'd1);
    chk("pre_rst_dacdat", 32'(dacdat), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bclk",   32'(bclk),           32'd0);
    chk("mid_rst_lrclk",  32'(lrclk),          32'd0);
    chk("mid_rst_dacdat", 32'(dacdat),         32'd0);
    chk("mid_rst_ready",  32'(wr.write_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(1100);

    chk("frames_checked", 32'(n_frames), 32'd12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
